lsu_mmio_hs: RTL

- Parametrised load-store unit for the RV32I core: byte-enable data RAM plus memory-mapped I/O (LEDR, LEDG, N_HEX seven-segment digits, LCD, switches, buttons).
- Adds a valid/ready request/response handshake, synchronous-read RAM, error reporting for misaligned, unmapped and illegal accesses, and synchronised inputs.
- Sits between the core's MEM stage and board I/O.

---
 rtl/lsu_pkg.sv | 67 ++++++
 rtl/lsu_dmem.sv | 27 ++
 rtl/lsu_mmio_hs.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and byte-lane helpers for the MMIO load-store unit.
package lsu_pkg;

  localparam logic [15:0] LEDR_ADDR = 16'h7000;
  localparam logic [15:0] LEDG_ADDR = 16'h7010;
  localparam logic [15:0] SEG7_ADDR = 16'h7020;
  localparam logic [15:0] LCD_ADDR  = 16'h7030;
  localparam logic [15:0] SW_ADDR   = 16'h7800;
  localparam logic [15:0] BTN_ADDR  = 16'h7810;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAM_RD = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] lane_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   return 4'b0001 << off;
      F3_SH:   return 4'b0011 << off;
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_SB:   return {4{data[7:0]}};
      F3_SH:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_LB:   return {{24{sh[7]}}, sh[7:0]};
      F3_LH:   return {{16{sh[15]}}, sh[15:0]};
      F3_LW:   return sh;
      F3_LBU:  return {24'd0, sh[7:0]};
      F3_LHU:  return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Synchronous-read data RAM with per-byte write enables; contents are not reset.
module lsu_dmem #(
  parameter int WORDS = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_r [WORDS];
  logic [31:0] rdata_r;

  // Byte-lane writes and registered read; read data holds between read strobes
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) mem_r[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) rdata_r <= mem_r[i_addr];
  end

  assign o_rdata = rdata_r;

endmodule

// File: rtl/lsu_mmio_hs.sv
// Load-store unit with valid/ready handshake: data RAM plus memory-mapped board I/O.
module lsu_mmio_hs
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
  parameter int          DMEM_WORDS = 64,
  parameter int          N_HEX      = 8,
  parameter int          LEDR_W     = 17,
  parameter int          LEDG_W     = 8,
  parameter int          SW_W       = 18,
  parameter int          BTN_W      = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_wren,
  input  logic [2:0]         i_funct3,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_st_data,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [31:0]        o_ld_data,
  output logic               o_rsp_err,
  input  logic [SW_W-1:0]    i_io_sw,
  input  logic [BTN_W-1:0]   i_io_btn,
  output logic [LEDR_W-1:0]  o_io_ledr,
  output logic [LEDG_W-1:0]  o_io_ledg,
  output logic [N_HEX*7-1:0] o_io_hex,
  output logic [31:0]        o_io_lcd
);

  localparam int          AW        = $clog2(DMEM_WORDS);
  localparam int          SEG_WORDS = N_HEX / 4;
  localparam logic [32:0] DMEM_END  = {1'b0, DMEM_BASE} + 33'(4 * DMEM_WORDS);

  lsu_state_e        state_r, state_nx_s;
  logic              req_ready_r, rsp_valid_r, rsp_err_r;
  logic [31:0]       ld_data_r;
  logic [2:0]        f3_r;
  logic [1:0]        off_r;
  logic [LEDR_W-1:0] ledr_r;
  logic [LEDG_W-1:0] ledg_r;
  logic [31:0]       lcd_r;
  logic [7:0]        seg_r [N_HEX];
  logic [7:0]        seg_pad_s [16];
  logic [SW_W-1:0]   sw_meta_r, sw_sync_r;
  logic [BTN_W-1:0]  btn_meta_r, btn_sync_r;
  logic [31:0]       io_rdata_s, ram_rdata_s, wdata_s;
  logic [3:0]        strb_s, ram_we_s;
  logic [AW-1:0]     ram_idx_s;

  // Address decode: every window requires the upper half-word to be zero
  logic hi_zero_s, is_dmem_s, is_ledr_s, is_ledg_s, is_seg_s, is_lcd_s, is_sw_s, is_btn_s;
  assign hi_zero_s = (i_addr[31:16] == 16'h0000);
  assign is_dmem_s = hi_zero_s && ({1'b0, i_addr} >= {1'b0, DMEM_BASE}) && ({1'b0, i_addr} < DMEM_END);
  assign is_ledr_s = hi_zero_s && (i_addr[15:2] == LEDR_ADDR[15:2]);
  assign is_ledg_s = hi_zero_s && (i_addr[15:2] == LEDG_ADDR[15:2]);
  assign is_lcd_s  = hi_zero_s && (i_addr[15:2] == LCD_ADDR[15:2]);
  assign is_sw_s   = hi_zero_s && (i_addr[15:2] == SW_ADDR[15:2]);
  assign is_btn_s  = hi_zero_s && (i_addr[15:2] == BTN_ADDR[15:2]);
  assign is_seg_s  = hi_zero_s && (i_addr[15:4] == SEG7_ADDR[15:4]) &&
                     ({30'd0, i_addr[3:2]} < 32'(SEG_WORDS));

  logic mis_s, bad_f3_s, mapped_s, err_s, accept_s, wr_ok_s, ram_re_s;
  assign mis_s    = ((i_funct3[1:0] == 2'd1) && i_addr[0]) ||
                    ((i_funct3[1:0] == 2'd2) && (i_addr[1:0] != 2'b00));
  assign bad_f3_s = i_req_wren ? (i_funct3 > 3'd2)
                               : ((i_funct3 == 3'd3) || (i_funct3 == 3'd6) || (i_funct3 == 3'd7));
  assign mapped_s = is_dmem_s | is_ledr_s | is_ledg_s | is_seg_s | is_lcd_s | is_sw_s | is_btn_s;
  assign err_s    = bad_f3_s | mis_s | ~mapped_s | (i_req_wren & (is_sw_s | is_btn_s));
  assign accept_s = i_req_valid && (state_r == IDLE);
  assign wr_ok_s  = accept_s && i_req_wren && !err_s;
  assign ram_re_s = accept_s && !i_req_wren && is_dmem_s && !err_s;

  assign strb_s    = lane_strobe(i_funct3, i_addr[1:0]);
  assign wdata_s   = store_replicate(i_funct3, i_st_data);
  assign ram_we_s  = (wr_ok_s && is_dmem_s) ? strb_s : 4'b0000;
  assign ram_idx_s = AW'((i_addr - DMEM_BASE) >> 2'd2);

  lsu_dmem #(.WORDS(DMEM_WORDS), .AW(AW)) u_dmem (
    .i_clk   (i_clk),
    .i_we    (ram_we_s),
    .i_re    (ram_re_s),
    .i_addr  (ram_idx_s),
    .i_wdata (wdata_s),
    .o_rdata (ram_rdata_s)
  );

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
      btn_meta_r <= '0;
      btn_sync_r <= '0;
    end else begin
      sw_meta_r  <= i_io_sw;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= i_io_btn;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Digits beyond N_HEX read as zero so the readback index never leaves the array
  for (genvar g = 0; g < 16; g++) begin : g_seg_pad
    if (g < N_HEX) begin : g_real
      assign seg_pad_s[g] = seg_r[g];
    end else begin : g_zero
      assign seg_pad_s[g] = 8'h00;
    end
  end

  // I/O readback word for the addressed register
  always_comb begin
    io_rdata_s = 32'd0;
    if (is_ledr_s) io_rdata_s = 32'(ledr_r);
    else if (is_ledg_s) io_rdata_s = 32'(ledg_r);
    else if (is_seg_s) io_rdata_s = {seg_pad_s[{i_addr[3:2], 2'd3}], seg_pad_s[{i_addr[3:2], 2'd2}],
                                     seg_pad_s[{i_addr[3:2], 2'd1}], seg_pad_s[{i_addr[3:2], 2'd0}]};
    else if (is_lcd_s) io_rdata_s = lcd_r;
    else if (is_sw_s) io_rdata_s = 32'(sw_sync_r);
    else if (is_btn_s) io_rdata_s = 32'(btn_sync_r);
    else io_rdata_s = 32'd0;
  end

  // Output registers, written with byte strobes at the accept edge
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ledr_r <= '0;
      ledg_r <= '0;
      lcd_r  <= 32'd0;
      for (int i = 0; i < N_HEX; i++) seg_r[i] <= 8'h00;
    end else if (wr_ok_s) begin
      if (is_ledr_s) ledr_r <= LEDR_W'(byte_merge(32'(ledr_r), wdata_s, strb_s));
      if (is_ledg_s) ledg_r <= LEDG_W'(byte_merge(32'(ledg_r), wdata_s, strb_s));
      if (is_lcd_s)  lcd_r  <= byte_merge(lcd_r, wdata_s, strb_s);
      for (int i = 0; i < N_HEX; i++) begin
        if (is_seg_s && (i_addr[3:2] == 2'(i / 4)) && strb_s[i % 4])
          seg_r[i] <= wdata_s[8*(i % 4) +: 8];
      end
    end
  end

  for (genvar g = 0; g < N_HEX; g++) begin : g_hex
    assign o_io_hex[7*g +: 7] = seg_r[g][6:0];
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_r <= IDLE;
    else         state_r <= state_nx_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = ram_re_s ? RAM_RD : RESP;
        else          state_nx_s = IDLE;
      end
      RAM_RD: state_nx_s = RESP;
      RESP: begin
        if (i_rsp_ready) state_nx_s = IDLE;
        else             state_nx_s = RESP;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Response registers: loaded at accept or after the RAM read, then held until consumed
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      ld_data_r   <= 32'd0;
      f3_r        <= 3'd0;
      off_r       <= 2'd0;
    end else begin
      req_ready_r <= (state_nx_s == IDLE);
      rsp_valid_r <= (state_nx_s == RESP);
      if (accept_s) begin
        f3_r  <= i_funct3;
        off_r <= i_addr[1:0];
        if (err_s) begin
          ld_data_r <= 32'd0;
          rsp_err_r <= 1'b1;
        end else if (i_req_wren || is_dmem_s) begin
          ld_data_r <= 32'd0;
          rsp_err_r <= 1'b0;
        end else begin
          ld_data_r <= load_extend(i_funct3, i_addr[1:0], io_rdata_s);
          rsp_err_r <= 1'b0;
        end
      end else if (state_r == RAM_RD) begin
        ld_data_r <= load_extend(f3_r, off_r, ram_rdata_s);
      end
    end
  end

  assign o_req_ready = req_ready_r;
  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_err   = rsp_err_r;
  assign o_ld_data   = ld_data_r;
  assign o_io_ledr   = ledr_r;
  assign o_io_ledg   = ledg_r;
  assign o_io_lcd    = lcd_r;

endmodule
